// File: rtl/dma_fifo_pkg.sv
// dma_fifo_pkg
//   Shared definitions for the DMA async FIFO read and write pointer
//   controllers: default pointer width, FIFO depth and the binary-to-Gray
//   helper used when publishing a pointer to the opposite clock domain.
package dma_fifo_pkg;

    localparam int FIFO_PTR = 4;
    localparam int DEPTH    = 2 ** FIFO_PTR;

    // Width-generic Gray encode; callers cast to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_to_binary.sv
// gray_to_binary
//   Combinational Gray-to-binary decoder for a PTR+1 bit FIFO pointer.
//   Ports:
//     gray  in   PTR+1  Gray-coded pointer
//     bin   out  PTR+1  binary equivalent
module gray_to_binary #(
    parameter int PTR = 4
) (
    input  logic [PTR:0] gray,
    output logic [PTR:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin      = '0;
        bin[PTR] = gray[PTR];
        for (int i = PTR - 1; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/fifo_rd_ptr_ctrl.sv
// fifo_rd_ptr_ctrl
//   Read-side pointer and flag controller of the DMA async FIFO, clocked in
//   the read domain. Keeps the binary read pointer, publishes its registered
//   Gray form to the write domain, synchronises the write Gray pointer through
//   two flops and produces registered empty / almost_empty / fill level.
//   Ports:
//     clk            in   1      read-domain clock
//     rst            in   1      synchronous active-high reset
//     rd_en          in   1      read request
//     wr_gray_async  in   PTR+1  Gray write pointer from the write domain
//     rd_ack         out  1      read accepted this cycle (combinational)
//     rd_addr        out  PTR    RAM read address
//     rd_gray        out  PTR+1  registered Gray read pointer
//     empty          out  1      registered empty flag
//     almost_empty   out  1      registered, level <= ALMOST_EMPTY_TH
//     rd_level       out  PTR+1  registered fill level, 0 .. 2**PTR
//     underflow      out  1      pulse the cycle after a refused read
module fifo_rd_ptr_ctrl
    import dma_fifo_pkg::*;
#(
    parameter int PTR             = FIFO_PTR,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rd_en,
    input  logic [PTR:0] wr_gray_async,
    output logic         rd_ack,
    output logic [PTR-1:0] rd_addr,
    output logic [PTR:0] rd_gray,
    output logic         empty,
    output logic         almost_empty,
    output logic [PTR:0] rd_level,
    output logic         underflow
);

    localparam logic [PTR:0] AE_TH = (PTR + 1)'(ALMOST_EMPTY_TH);

    if (ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH >= (1 << PTR)) begin : g_bad_th
        $error("fifo_rd_ptr_ctrl: ALMOST_EMPTY_TH must be in 0 .. 2**PTR-1");
    end

    logic [PTR:0] rd_bin;
    logic [PTR:0] rd_bin_next;
    logic [PTR:0] rd_gray_next;
    logic [PTR:0] wq1;
    logic [PTR:0] wq2;
    logic [PTR:0] wr_bin_s;
    logic [PTR:0] level_next;
    logic         fire;

    gray_to_binary #(.PTR(PTR)) u_g2b (
        .gray (wq2),
        .bin  (wr_bin_s)
    );

    assign fire    = rd_en & ~empty;
    assign rd_ack  = fire;
    assign rd_addr = rd_bin[PTR-1:0];

    // Flags are computed from the next-state pointer so a read of the last
    // entry shows empty on the very next edge; no stale second read can fire.
    always_comb begin
        rd_bin_next  = rd_bin + {{PTR{1'b0}}, fire};
        rd_gray_next = (PTR + 1)'(bin2gray(32'(rd_bin_next)));
        // Modulo PTR+1 subtraction stays correct across pointer wrap.
        level_next   = wr_bin_s - rd_bin_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bin       <= '0;
            rd_gray      <= '0;
            wq1          <= '0;
            wq2          <= '0;
            rd_level     <= '0;
            underflow    <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
        end else begin
            rd_bin       <= rd_bin_next;
            rd_gray      <= rd_gray_next;
            wq1          <= wr_gray_async;
            wq2          <= wq1;
            empty        <= (rd_gray_next == wq2);
            rd_level     <= level_next;
            almost_empty <= (level_next <= AE_TH);
            underflow    <= rd_en & empty;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
module tb_fifo_rd_ptr_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd_en;
    logic [4:0] wr_gray_async;
    logic       rd_ack;
    logic [3:0] rd_addr;
    logic [4:0] rd_gray;
    logic       empty;
    logic       almost_empty;
    logic [4:0] rd_level;
    logic       underflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Write side modelled as a plain count of entries written, modulo 32.
    logic [4:0] wr_cnt;
    assign wr_gray_async = wr_cnt ^ (wr_cnt >> 1);

    // Reference model: read count, and write counts as seen two edges late.
    int m_rd, m_level, s1, s2;
    bit m_empty, m_almost, m_under;

    fifo_rd_ptr_ctrl #(.PTR(4), .ALMOST_EMPTY_TH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_en         (rd_en),
        .wr_gray_async (wr_gray_async),
        .rd_ack        (rd_ack),
        .rd_addr       (rd_addr),
        .rd_gray       (rd_gray),
        .empty         (empty),
        .almost_empty  (almost_empty),
        .rd_level      (rd_level),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    // Advance the model with the current inputs, then clock the DUT and
    // return on the following falling edge.
    task automatic tick();
        int fire, nrd, lvl;
        if (rst) begin
            m_rd = 0; s1 = 0; s2 = 0; m_level = 0;
            m_empty = 1; m_almost = 1; m_under = 0;
        end else begin
            fire    = (rd_en && !m_empty) ? 1 : 0;
            nrd     = (m_rd + fire) % 32;
            lvl     = (s2 - nrd + 32) % 32;
            m_under = rd_en && m_empty;
            m_rd    = nrd;
            m_level = lvl;
            m_empty = (lvl == 0);
            m_almost = (lvl <= 2);
            s2 = s1;
            s1 = int'(wr_cnt);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; rd_en = 0; wr_cnt = 0;
        tick(); tick();
        rst = 0;
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %0b exp 1", empty); end
        n_tests++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_almost got %0b exp 1", almost_empty); end
        n_tests++; if (rd_level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", rd_level); end
        n_tests++; if (rd_addr !== 4'd0) begin n_fail++; $display("FAIL reset_addr got %0d exp 0", rd_addr); end
        n_tests++; if (rd_gray !== 5'd0) begin n_fail++; $display("FAIL reset_gray got %b exp 00000", rd_gray); end
        n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow got %0b exp 0", underflow); end
    endtask

    task automatic test_sync_latency();
        wr_cnt = 5'd1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_tests++;
            if (empty !== (e < 3)) begin n_fail++; $display("FAIL sync_empty edge %0d got %0b exp %0b", e, empty, e < 3); end
            n_tests++;
            if (rd_level !== ((e < 3) ? 5'd0 : 5'd1)) begin n_fail++; $display("FAIL sync_level edge %0d got %0d", e, rd_level); end
            n_tests++;
            if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL sync_almost edge %0d got %0b exp 1", e, almost_empty); end
        end
    endtask

    task automatic test_full_drain();
        int acks;
        bit done;
        // Fill to 16 one Gray step per edge, then let it cross the synchroniser.
        for (int i = 2; i <= 16; i++) begin wr_cnt = 5'(i); tick(); end
        tick(); tick(); tick();
        n_tests++; if (rd_level !== 5'd16 || empty !== 1'b0) begin n_fail++; $display("FAIL drain_full got level %0d empty %0b exp 16 0", rd_level, empty); end
        rd_en = 1; acks = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            n_tests++; if (rd_ack !== !m_empty) begin n_fail++; $display("FAIL drain_ack got %0b exp %0b", rd_ack, !m_empty); end
            if (rd_ack) begin
                n_tests++; if (rd_addr !== 4'(acks)) begin n_fail++; $display("FAIL drain_addr got %0d exp %0d", rd_addr, acks); end
                acks++;
            end
            tick();
            n_tests++; if (rd_level !== 5'(m_level)) begin n_fail++; $display("FAIL drain_level got %0d exp %0d", rd_level, m_level); end
            n_tests++; if (almost_empty !== m_almost) begin n_fail++; $display("FAIL drain_almost got %0b exp %0b level %0d", almost_empty, m_almost, m_level); end
            if (empty) done = 1;
        end
        n_tests++; if (!done) begin n_fail++; $display("FAIL drain_timeout empty never rose"); end
        n_tests++; if (acks != 16) begin n_fail++; $display("FAIL drain_acks got %0d exp 16", acks); end
        n_tests++; if (rd_gray !== 5'b11000) begin n_fail++; $display("FAIL drain_gray got %b exp 11000", rd_gray); end
        n_tests++; if (rd_level !== 5'd0) begin n_fail++; $display("FAIL drain_level_end got %0d exp 0", rd_level); end
    endtask

    task automatic test_underflow();
        bit pat [4] = '{1, 0, 1, 1};
        for (int i = 0; i < 4; i++) begin
            rd_en = pat[i];
            #1;
            n_tests++; if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL under_ack got %0b exp 0", rd_ack); end
            tick();
            n_tests++; if (underflow !== pat[i]) begin n_fail++; $display("FAIL under_pulse step %0d got %0b exp %0b", i, underflow, pat[i]); end
            n_tests++; if (rd_addr !== 4'd0) begin n_fail++; $display("FAIL under_addr got %0d exp 0", rd_addr); end
        end
        rd_en = 0; tick();
        n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL under_clear got %0b exp 0", underflow); end
    endtask

    task automatic test_wrap();
        // Bring the read pointer to 30 with an empty FIFO.
        rd_en = 1;
        for (int i = 17; i <= 30; i++) begin wr_cnt = 5'(i); tick(); end
        for (int i = 0; i < 20 && !(m_rd == 30 && m_empty); i++) tick();
        rd_en = 0;
        n_tests++; if (rd_gray !== gray5(30) || empty !== 1'b1) begin n_fail++; $display("FAIL wrap_setup gray %b empty %0b", rd_gray, empty); end
        wr_cnt = 5'd31; tick();
        wr_cnt = 5'd0;  tick();
        tick(); tick(); tick();
        n_tests++; if (rd_level !== 5'd2) begin n_fail++; $display("FAIL wrap_level got %0d exp 2", rd_level); end
        rd_en = 1;
        #1;
        n_tests++; if (rd_ack !== 1'b1 || rd_addr !== 4'd14) begin n_fail++; $display("FAIL wrap_rd1 ack %0b addr %0d exp 1 14", rd_ack, rd_addr); end
        tick();
        n_tests++; if (rd_ack !== 1'b1 || rd_addr !== 4'd15 || rd_gray !== gray5(31)) begin n_fail++; $display("FAIL wrap_rd2 ack %0b addr %0d gray %b", rd_ack, rd_addr, rd_gray); end
        tick();
        rd_en = 0;
        n_tests++; if (empty !== 1'b1 || rd_gray !== 5'b00000 || rd_addr !== 4'd0) begin n_fail++; $display("FAIL wrap_end empty %0b gray %b addr %0d exp 1 00000 0", empty, rd_gray, rd_addr); end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 5; i++) begin wr_cnt = 5'(i); tick(); end
        tick(); tick(); tick();
        n_tests++; if (rd_level !== 5'd5 || wr_gray_async !== 5'b00111) begin n_fail++; $display("FAIL rmid_setup level %0d exp 5", rd_level); end
        rst = 1; rd_en = 1; tick();
        rst = 0; rd_en = 0;
        n_tests++; if (empty !== 1'b1 || rd_addr !== 4'd0 || rd_gray !== 5'd0 || rd_level !== 5'd0) begin n_fail++; $display("FAIL rmid_reset empty %0b addr %0d gray %b level %0d", empty, rd_addr, rd_gray, rd_level); end
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_tests++;
            if (empty !== (e < 3) || rd_level !== ((e < 3) ? 5'd0 : 5'd5)) begin n_fail++; $display("FAIL rmid_edge %0d empty %0b level %0d", e, empty, rd_level); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 99) < 2);
            rd_en = ($urandom_range(0, 99) < 55);
            if (rst) wr_cnt = 0;
            else if ($urandom_range(0, 99) < 50 && ((int'(wr_cnt) - m_rd + 32) % 32) < 16)
                wr_cnt = wr_cnt + 5'd1;
            #1;
            n_tests++; if (rd_ack !== (rd_en && !m_empty)) begin n_fail++; $display("FAIL rnd_ack cyc %0d got %0b", i, rd_ack); end
            tick();
            n_tests++;
            if (empty !== m_empty || rd_level !== 5'(m_level) || almost_empty !== m_almost ||
                underflow !== m_under || rd_addr !== 4'(m_rd % 16) || rd_gray !== gray5(m_rd)) begin
                n_fail++;
                $display("FAIL rnd_state cyc %0d got e%0b l%0d a%0b u%0b addr%0d g%b exp e%0b l%0d a%0b u%0b rd%0d",
                         i, empty, rd_level, almost_empty, underflow, rd_addr, rd_gray,
                         m_empty, m_level, m_almost, m_under, m_rd);
            end
        end
        rst = 0; rd_en = 0;
    endtask

    initial begin
        rst = 1; rd_en = 0; wr_cnt = 0;
        m_rd = 0; m_level = 0; s1 = 0; s2 = 0;
        m_empty = 1; m_almost = 1; m_under = 0;
        @(negedge clk);
        test_reset();
        test_sync_latency();
        test_full_drain();
        test_underflow();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
